// File: rtl/ripple_carry_adder.sv
// 8-bit ripple-carry adder: {E, F} = A + B + C, result registered.
// Define RIPPLECARRY_INREG_EN to also register A, B and C, for a latency of 2.

module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module ripple_carry_adder (
  output logic       E,
  output logic [7:0] F,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       C,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned W = 8;

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_c;
  logic [W:0]   carry;
  logic [W-1:0] sum_c;

`ifdef RIPPLECARRY_INREG_EN
  // Operand registers in front of the carry chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
      op_c <= 1'b0;
    end else begin
      op_a <= A;
      op_b <= B;
      op_c <= C;
    end
  end
`else
  assign op_a = A;
  assign op_b = B;
  assign op_c = C;
`endif

  // Carry ripples from bit 0 to bit W-1; no lookahead
  assign carry[0] = op_c;

  for (genvar i = 0; i < W; i++) begin : g_cell
    rca_full_adder u_fa (
      .a  (op_a[i]),
      .b  (op_b[i]),
      .ci (carry[i]),
      .s  (sum_c[i]),
      .co (carry[i+1])
    );
  end

  // Result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F <= '0;
      E <= 1'b0;
    end else begin
      F <= sum_c;
      E <= carry[W];
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder: delay-line reference model plus literal checks.

module tb_ripple_carry_adder;

`ifdef RIPPLECARRY_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       c = 1'b0;
  logic       e;
  logic [7:0] f;

  int checks = 0;
  int fails  = 0;
  bit cmp_on = 1'b0;

  ripple_carry_adder dut (
    .E     (e),
    .F     (f),
    .A     (a),
    .B     (b),
    .C     (c),
    .clk   (clk),
    .rst_n (rst_n)
  );

  always #5 clk = ~clk;

  // Reference: 9-bit sum of the operands, delayed by LAT clock edges
  logic [8:0] stg [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) stg[i] = 9'd0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) stg[i] = stg[i-1];
      stg[0] = 9'(a) + 9'(b) + 9'(c);
    end
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {E,F}=%h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_on) check("model", {e, f}, rst_n ? stg[LAT-1] : 9'd0);
  end

  task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    @(negedge clk);
    a = va;
    b = vb;
    c = vc;
  endtask

  // Apply one vector, hold it through the latency, then check a literal result
  task automatic vec_literal(input string name, input logic [7:0] va, input logic [7:0] vb,
                             input logic vc, input logic [8:0] exp);
    drive(va, vb, vc);
    repeat (LAT) @(posedge clk);
    #1;
    check(name, {e, f}, exp);
  endtask

  initial begin
    int hits;
    int first_k;

    // Reset held with all-ones operands while the clock runs
    a = 8'hFF; b = 8'hFF; c = 1'b1;
    cmp_on = 1'b1;
    #1;
    check("reset_initial", {e, f}, 9'd0);
    repeat (4) @(posedge clk);
    #1;
    check("reset_held", {e, f}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed anchors
    vec_literal("wrap_ff_01",   8'hFF, 8'h01, 1'b0, 9'h100);
    vec_literal("wrap_ff_00_c", 8'hFF, 8'h00, 1'b1, 9'h100);
    vec_literal("ripple_full",  8'hFF, 8'hFF, 1'b1, 9'h1FF);
    vec_literal("msb_80_80",    8'h80, 8'h80, 1'b0, 9'h100);
    vec_literal("small_sum",    8'h12, 8'h34, 1'b1, 9'h047);
    vec_literal("zero",         8'h00, 8'h00, 1'b0, 9'h000);

    // Latency: one-cycle pulse of 0x10 + 0x20 + 1
    drive(8'h10, 8'h20, 1'b1);
    @(posedge clk);
    hits = 0;
    first_k = -1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (f == 8'h31 && e == 1'b0) begin
        hits++;
        if (first_k < 0) first_k = k;
      end
      if (k == 0) begin
        a = 8'h00; b = 8'h00; c = 1'b0;
      end
    end
    check("latency_hits", 9'(hits), 9'd1);
    check("latency_pos", 9'(first_k), 9'(LAT - 1));

    // Exhaustive low range, new operands every cycle
    for (int ci = 0; ci < 2; ci++)
      for (int ia = 0; ia < 32; ia++)
        for (int ib = 0; ib < 32; ib++)
          drive(8'(ia), 8'(ib), 1'(ci));

    // Asynchronous reset in mid-cycle after a nonzero result
    vec_literal("pre_reset", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {e, f}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after_release", {e, f}, 9'd0);

    // Random regression
    for (int n = 0; n < 10000; n++)
      drive(8'($urandom), 8'($urandom), 1'($urandom));
    repeat (LAT + 1) @(negedge clk);
    cmp_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder.md
# ripple_carry_adder

8-bit ripple-carry adder with carry-in and carry-out, built as a chain of eight 1-bit full adders with registered results. It is the basic arithmetic primitive of the structural library. Datapaths use it wherever an A + B + Cin sum with carry-out is needed and a one-cycle registered result is acceptable.

## Interface

Parameters:
- None. Width is fixed at 8 bits.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- E  output  1  registered carry-out of bit 7.
- F  output  8  registered sum bits [7:0].
- A  input  8  addend A, unsigned.
- B  input  8  addend B, unsigned.
- C  input  1  carry-in into bit 0.

Port order for positional instantiation: E, F, A, B, C, then clk, rst_n as the last two.

## Operation

- Combinational core: eight full-adder cells, cell i computes:
  - s[i] = A[i] ^ B[i] ^ c[i]
  - c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]))
  - c[0] = C
- Carry ripples LSB to MSB; no lookahead.
- Result is the 9-bit unsigned value {E, F} = A + B + C, range 0..511.
- Unsigned semantics only; no signed-overflow flag.
- E = 1 exactly when A + B + C >= 256. F wraps modulo 256.
- No enable, no valid handshake. The adder samples inputs every cycle.

## Timing

- Reset: while rst_n = 0, F = 8'h00 and E = 0, immediately and independent of clk.
- Reset deassertion is sampled on the next rising clk edge. The first result register load happens on the first rising edge with rst_n = 1.
- Latency, default build: 1 cycle. Inputs present before rising edge N appear on F/E after edge N.
- Throughput: one addition per cycle; back-to-back operands are fully pipelined.
- Input changes between edges have no effect on the outputs until the next edge; outputs never glitch.
- Reset asserted mid-operation: the in-flight result is discarded and outputs go to 0 at once. No stale result appears after reset release.
- Critical path: input register (if present) -> 8-cell carry chain -> output register. Must close at the library's target clock.

## Configuration

- Macro: RIPPLECARRY_INREG_EN.
- Defined:
  - A, B and C are captured in input registers that reset to 0 asynchronously.
  - The carry chain is fed from these registers and its output is registered as above.
  - Latency is 2 cycles.
  - During the first cycle after reset release, outputs show 0 + 0 + 0, i.e. F = 0, E = 0.
- Not defined:
  - Inputs feed the carry chain directly.
  - Latency is 1 cycle.
- Port list and arithmetic behaviour are identical in both builds; only latency differs.

## Test plan

- Reset: hold rst_n = 0 with A = 8'hFF, B = 8'hFF, C = 1 and toggle clk -> F = 0, E = 0 throughout. Assert rst_n low mid-cycle after a nonzero result -> outputs clear without waiting for a clock edge.
- Exhaustive low range: sweep A = 0..31, B = 0..31, C = 0 then 1, changing inputs each cycle -> after the configured latency, F = A + B + C and E = 0 for every vector (maximum is 31 + 31 + 1 = 63).
- Carry-out wrap: A = 8'hFF, B = 8'h01, C = 0 -> F = 8'h00, E = 1. With A = 8'hFF, B = 8'h00, C = 1 -> F = 8'h00, E = 1.
- Full carry ripple: A = 8'hFF, B = 8'hFF, C = 1 -> F = 8'hFF, E = 1. With A = 8'h80, B = 8'h80, C = 0 -> F = 8'h00, E = 1.
- Latency check: apply A = 8'h10, B = 8'h20, C = 1 for one cycle, then zeros -> exactly one output cycle shows F = 8'h31, E = 0, at edge N (default build) or N+1 (RIPPLECARRY_INREG_EN defined).
- Random regression: 10,000 random A, B, C vectors -> {E, F} equals A + B + C computed 9-bit wide, delayed by the configured latency.
